uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Serial receive front end that sits directly upstream of the system top's receive path. It samples the asynchronous rxd_line, deframes 8N1 characters using 16x oversampling and buffers them in a small FIFO. The FIFO is drained by the consumer through a valid/ready handshake. It also reports framing and overrun errors as single-cycle pulses.

Parameters:
DIV, 27, clock cycles per oversample tick (clock/(baud*16)); legal range 2..65535
FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
rxd_line  input  1  serial receive line, idle high, asynchronous to clock
rx_data  output  8  FIFO head byte; valid only while rx_valid=1
rx_valid  output  1  FIFO non-empty
rx_ready  input  1  consumer accepts the head byte when rx_valid&rx_ready
rx_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: good byte received while FIFO full, byte dropped

Behaviour:
- Reset (async, active-high): synchronizer flops=1, state=IDLE, tick counter=0, sample counter=0, shift register=0, FIFO pointers=0. Outputs: rx_valid=0, rx_count=0, rx_data=0, frame_err=0, overrun=0.
- Input synchronizer: rxd_line passes through 2 flops before use (rxd_s). This adds 2 cycles of latency.
- Tick generator: counter 0..DIV-1 produces a 1-cycle tick when the count equals DIV-1, then wraps to 0. The counter is forced to 0 on the cycle start is detected, which aligns sampling to the start edge.
- Sample counter: 4-bit, advances on each tick, 16 ticks per bit.
- FSM:
  - IDLE: when rxd_s=0, go to START; clear the tick and sample counters.
  - START: at sample count 7 (mid-bit), if rxd_s=0 go to DATA with bit index 0; if rxd_s=1 (glitch) return to IDLE with no error.
  - DATA: every 16 ticks after the start midpoint, sample rxd_s and shift it in LSB first. After bit index 7 is sampled, go to STOP.
  - STOP: 16 ticks after the bit-7 sample, sample rxd_s.
    - If high: push the byte (or pulse overrun if the FIFO is full and not popping this cycle), then go to IDLE.
    - If low: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rxd_s=1, then go to IDLE. This prevents a held-low line from being read as repeated characters.
- FIFO:
  - Push occurs on the cycle after the stop-bit sample.
  - Pop occurs when rx_valid & rx_ready.
  - rx_data is the registered head. rx_valid = (count≠0).
  - First-byte latency: rx_valid rises the cycle after the push cycle.
- Simultaneous push and pop:
  - When full: allowed. Pop frees an entry, the push is accepted, count stays unchanged, no overrun.
  - When empty: a pop cannot happen (rx_valid=0). The push lands normally.
- Pointer wrap: pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Full/empty are decided by the count, not by the pointers.
- rx_ready while rx_valid=0 is ignored.
- frame_err and overrun are never asserted together, and neither lasts more than 1 cycle per character.
- Reset mid-character: the partial byte is lost and FIFO contents are discarded. After deassertion the receiver waits in IDLE for the next falling edge.
- A line held high produces no activity. Back-to-back characters with 1 stop bit are received without loss.

Test Plan:
- Use DIV=4 throughout, so 1 bit = 64 clocks. Send 0xA5 (8N1), rx_ready=1 → rx_valid pulses 1 cycle with rx_data=0xA5; no error pulses.
- Send 0x00, 0xFF, 0x3C back-to-back with rx_ready=0 → rx_count=3. Then pop 1 per cycle with rx_ready=1 → data in order 0x00, 0xFF, 0x3C; rx_count returns to 0.
- Send 5 bytes 0x01..0x05 with rx_ready=0 (FIFO_DEPTH=4) → 0x01..0x04 stored, overrun pulse exactly once on the 5th, rx_count=4.
- Fill the FIFO, then send a 5th byte with rx_ready=1 asserted on the push cycle → no overrun, rx_count stays 4, and the 5th byte emerges last.
- Drive a 20-clock low glitch on rxd_line → no push, no error, FSM back in IDLE. Send 0x55 with the stop bit low, then hold the line low for 10 bit times → one frame_err pulse, no push, no further characters until the line goes high.
- Assert reset during bit 4 of a byte with 2 bytes queued → rx_valid=0 and rx_count=0 immediately. The next full byte 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 8N1 UART receiver (16x oversampling) feeding a valid/ready FIFO
// Revision : 1.0
// ============================================================================
module uart_rx_fifo #(
    parameter int DIV        = 27,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          rxd_line,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int          c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int          c_CNT_W  = c_PTR_W + 1;
    localparam logic [15:0] c_DIV_M1 = 16'(DIV - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_BREAK = 3'd4;

    logic                r_sync1, r_sync2;
    logic                w_rxd_s;
    logic [15:0]         r_tick_cnt;
    logic                w_tick, w_start_det, w_mid, w_bit_end;
    logic [2:0]          r_state;
    logic [3:0]          r_samp_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_push;
    logic                r_frame_err;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr, r_rd_ptr, w_rd_inc;
    logic [c_CNT_W-1:0]  r_count;
    logic [7:0]          r_head, w_head_next;
    logic                r_overrun;
    logic                w_full, w_pop, w_push;

    assign w_rxd_s = r_sync2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd_line;
            r_sync2 <= r_sync1;
        end
    end

    // Restarting the divider on the start edge centres every sample in its bit.
    assign w_tick      = (r_tick_cnt == c_DIV_M1);
    assign w_start_det = (r_state == c_ST_IDLE) && !w_rxd_s;
    assign w_mid       = w_tick && (r_samp_cnt == 4'd7);
    assign w_bit_end   = w_tick && (r_samp_cnt == 4'd15);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= 16'd0;
        end else if (w_start_det || w_tick) begin
            r_tick_cnt <= 16'd0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_samp_cnt  <= 4'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'd0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_tick) begin
                r_samp_cnt <= r_samp_cnt + 4'd1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_rxd_s) begin
                        r_state    <= c_ST_START;
                        r_samp_cnt <= 4'd0;
                    end
                end
                c_ST_START: begin
                    if (w_mid) begin
                        if (!w_rxd_s) begin
                            r_state    <= c_ST_DATA;
                            r_bit_idx  <= 3'd0;
                            r_samp_cnt <= 4'd0;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_shift   <= {w_rxd_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_ST_STOP;
                        end
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        if (w_rxd_s) begin
                            r_push  <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= c_ST_BREAK;
                        end
                    end
                end
                c_ST_BREAK: begin
                    if (w_rxd_s) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign w_full   = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_pop    = rx_valid && rx_ready;
    assign w_push   = r_push && (!w_full || w_pop);
    assign w_rd_inc = r_rd_ptr + c_PTR_W'(1);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    // Head register tracks the entry at the read pointer after this cycle;
    // a byte landing in an empty (or emptying) FIFO bypasses the array.
    always_comb begin
        w_head_next = r_head;
        if (w_pop) begin
            if (r_count == c_CNT_W'(1)) begin
                w_head_next = r_shift;
            end else begin
                w_head_next = r_mem[w_rd_inc];
            end
        end else if ((r_count == c_CNT_W'(0)) && w_push) begin
            w_head_next = r_shift;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_head    <= 8'd0;
            r_overrun <= 1'b0;
        end else begin
            r_head    <= w_head_next;
            r_overrun <= r_push && w_full && !w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_inc;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rx_data   = r_head;
    assign rx_valid  = (r_count != c_CNT_W'(0));
    assign rx_count  = r_count;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed self-checking bench for uart_rx_fifo (DIV=4, depth 4)
// Revision : 1.0
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DIV        = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int c_BIT      = 16 * DIV;
    // Negedges from start-bit launch to the push cycle: 2 sync + 1 detect
    // + 152 ticks of DIV cycles, sampled on the falling edge.
    localparam int c_PUSH_CYC = 611;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       rxd_line = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int fe_cnt, ov_cnt, both_cnt, valid_cycles;
    logic [7:0] popped [$];

    always #5 clock = ~clock;

    uart_rx_fifo #(.DIV(DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .rxd_line  (rxd_line),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_count  (rx_count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // Event recorder: counts pulses and captures every accepted byte.
    always begin
        @(negedge clock);
        #1;
        if (!reset) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err && overrun) both_cnt++;
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) popped.push_back(rx_data);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic clear_mon();
        fe_cnt = 0; ov_cnt = 0; both_cnt = 0; valid_cycles = 0;
        popped.delete();
    endtask

    task automatic idle(input int n);
        rxd_line = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd_line = 1'b0;
        repeat (c_BIT) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rxd_line = b[i];
            repeat (c_BIT) @(negedge clock);
        end
        rxd_line = stop;
        repeat (c_BIT) @(negedge clock);
    endtask

    task automatic pop_n(input int n);
        rx_ready = 1'b1;
        repeat (n) @(negedge clock);
        rx_ready = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", rx_valid); end
        checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", rx_count); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%0h exp=00", rx_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%0b exp=0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    endtask

    task automatic test_single();
        logic v_before, v_after;
        logic [7:0] d_after;
        clear_mon();
        rx_ready = 1'b1;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                repeat (c_PUSH_CYC) @(negedge clock);
                v_before = rx_valid;
                @(negedge clock);
                v_after = rx_valid;
                d_after = rx_data;
            end
        join
        idle(40);
        rx_ready = 1'b0;
        checks++; if (v_before !== 1'b0) begin errors++; $display("FAIL single_valid_on_push got=%0b exp=0", v_before); end
        checks++; if (v_after !== 1'b1) begin errors++; $display("FAIL single_valid_after_push got=%0b exp=1", v_after); end
        checks++; if (d_after !== 8'hA5) begin errors++; $display("FAIL single_data got=%0h exp=a5", d_after); end
        checks++; if (valid_cycles !== 1) begin errors++; $display("FAIL single_valid_width got=%0d exp=1", valid_cycles); end
        checks++; if (popped.size() !== 1) begin errors++; $display("FAIL single_pops got=%0d exp=1", popped.size()); end
        checks++; if (fe_cnt + ov_cnt !== 0) begin errors++; $display("FAIL single_err_pulses got=%0d exp=0", fe_cnt + ov_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [3] = '{8'h00, 8'hFF, 8'h3C};
        clear_mon();
        rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(exp_q[i], 1'b1);
        idle(20);
        checks++; if (rx_count !== 3'd3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", rx_count); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL b2b_head got=%0h exp=00", rx_data); end
        pop_n(3);
        checks++; if (popped.size() !== 3) begin errors++; $display("FAIL b2b_pops got=%0d exp=3", popped.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (popped[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_order[%0d] got=%0h exp=%0h", i, popped[i], exp_q[i]); end
        end
        checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL b2b_drained got=%0d exp=0", rx_count); end
    endtask

    task automatic test_overrun();
        clear_mon();
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        idle(20);
        checks++; if (rx_count !== 3'd4) begin errors++; $display("FAIL ovr_count got=%0d exp=4", rx_count); end
        checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL ovr_pulses got=%0d exp=1", ov_cnt); end
        checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL ovr_frame_err got=%0d exp=0", fe_cnt); end
        pop_n(4);
        for (int i = 0; i < 4; i++) begin
            checks++; if (popped[i] !== 8'(i + 1)) begin errors++; $display("FAIL ovr_order[%0d] got=%0h exp=%0h", i, popped[i], i + 1); end
        end
        checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL ovr_drained got=%0d exp=0", rx_count); end
    endtask

    task automatic test_full_pop();
        clear_mon();
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i), 1'b1);
        idle(20);
        fork
            send_byte(8'h15, 1'b1);
            begin
                repeat (c_PUSH_CYC) @(negedge clock);
                rx_ready = 1'b1;
                @(negedge clock);
                rx_ready = 1'b0;
            end
        join
        idle(20);
        checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL fullpop_overrun got=%0d exp=0", ov_cnt); end
        checks++; if (rx_count !== 3'd4) begin errors++; $display("FAIL fullpop_count got=%0d exp=4", rx_count); end
        pop_n(4);
        checks++; if (popped.size() !== 5) begin errors++; $display("FAIL fullpop_pops got=%0d exp=5", popped.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (popped[i] !== 8'h11 + 8'(i)) begin errors++; $display("FAIL fullpop_order[%0d] got=%0h exp=%0h", i, popped[i], 8'h11 + 8'(i)); end
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx_ready = 1'b0;
        rxd_line = 1'b0;
        repeat (20) @(negedge clock);
        idle(700);
        checks++; if (valid_cycles !== 0) begin errors++; $display("FAIL glitch_push got=%0d exp=0", valid_cycles); end
        checks++; if (fe_cnt + ov_cnt !== 0) begin errors++; $display("FAIL glitch_err got=%0d exp=0", fe_cnt + ov_cnt); end
        send_byte(8'h5A, 1'b1);
        idle(20);
        checks++; if (rx_count !== 3'd1) begin errors++; $display("FAIL glitch_next_count got=%0d exp=1", rx_count); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL glitch_next_data got=%0h exp=5a", rx_data); end
        pop_n(1);
    endtask

    task automatic test_frame();
        clear_mon();
        rx_ready = 1'b0;
        send_byte(8'h55, 1'b0);
        repeat (10 * c_BIT) @(negedge clock);
        checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL frame_pulses got=%0d exp=1", fe_cnt); end
        checks++; if (valid_cycles !== 0) begin errors++; $display("FAIL frame_push got=%0d exp=0", valid_cycles); end
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL frame_both got=%0d exp=0", both_cnt); end
        idle(200);
        checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL frame_after_break got=%0d exp=1", fe_cnt); end
        checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL frame_count got=%0d exp=0", rx_count); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] partial = 8'h99;
        clear_mon();
        rx_ready = 1'b0;
        send_byte(8'hC3, 1'b1);
        send_byte(8'h7E, 1'b1);
        idle(20);
        checks++; if (rx_count !== 3'd2) begin errors++; $display("FAIL rmid_queued got=%0d exp=2", rx_count); end
        rxd_line = 1'b0;
        repeat (c_BIT) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rxd_line = partial[i];
            repeat (c_BIT) @(negedge clock);
        end
        rxd_line = partial[4];
        repeat (c_BIT / 2) @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%0b exp=0", rx_valid); end
        checks++; if (rx_count !== 3'd0) begin errors++; $display("FAIL rmid_count got=%0d exp=0", rx_count); end
        @(negedge clock);
        rxd_line = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        idle(20);
        send_byte(8'h81, 1'b1);
        idle(20);
        checks++; if (rx_count !== 3'd1) begin errors++; $display("FAIL rmid_next_count got=%0d exp=1", rx_count); end
        checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL rmid_next_data got=%0h exp=81", rx_data); end
        pop_n(1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_full_pop();
        test_glitch();
        test_frame();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
